// File: rtl/matrix_fetch_pkg.sv
// Shared sizes, types and FSM encoding for the matrix operand server.
// Imported by the interface, the storage sub-module user and the top level.
package mat_pkg;
  localparam int N             = 32;
  localparam int DATA_W        = 8;
  localparam int IDX_W         = 5;
  localparam int BYTES_PER_MAT = 1024;
  localparam int CNT_W         = $clog2(2 * BYTES_PER_MAT);

  typedef logic [N-1:0][DATA_W-1:0] row_t;

  typedef enum logic [1:0] {
    FS_LOAD  = 2'd0,
    FS_READY = 2'd1,
    FS_RESP  = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/matrix_fetch_if.sv
// Load stream, request and response signals of matrix_fetch, bundled with
// a slave view for the server and a master view for whoever drives it.
interface matrix_fetch_if;
  import mat_pkg::*;

  // Load: byte_in is taken on every edge where byte_valid_in is high while
  // loading; there is no back-pressure. Request: new_request is sampled only
  // in the ready state; the answer is valid for exactly the one cycle where
  // val_rows is high, and data/index fields are held until the next answer.
  logic [DATA_W-1:0] byte_in;
  logic              byte_valid_in;
  logic              load_start_in;
  logic              new_request;
  logic [IDX_W-1:0]  row_req;
  logic [IDX_W-1:0]  col_req;

  logic              complete;
  row_t              matA_row;
  row_t              matB_col;
  logic [IDX_W-1:0]  row_in;
  logic [IDX_W-1:0]  col_in;
  logic              val_rows;
  logic              overflow_out;
  fetch_state_t      dbg_state;

  modport slave (
    input  byte_in, byte_valid_in, load_start_in, new_request, row_req, col_req,
    output complete, matA_row, matB_col, row_in, col_in, val_rows, overflow_out,
           dbg_state
  );

  modport master (
    output byte_in, byte_valid_in, load_start_in, new_request, row_req, col_req,
    input  complete, matA_row, matB_col, row_in, col_in, val_rows, overflow_out,
           dbg_state
  );
endinterface

// File: rtl/matrix_fetch_store.sv
// N words of N bytes: single-byte write port and a registered whole-word read.
// The read register doubles as the response output register of the top level.
module mat_store #(
    parameter int N      = 32,
    parameter int DATA_W = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     we_i,
    input  logic [$clog2(N)-1:0]     waddr_i,
    input  logic [$clog2(N)-1:0]     wlane_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(N)-1:0]     raddr_i,
    output logic [N-1:0][DATA_W-1:0] rdata_o
);
    logic [N-1:0][DATA_W-1:0] mem_q [N];
    logic [N-1:0][DATA_W-1:0] rdata_q;

    // Contents are deliberately left unreset so this maps onto plain storage.
    always_ff @(posedge clk_in) begin
        if (we_i) begin
            mem_q[waddr_i][wlane_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/matrix_fetch.sv
// Captures matrices A then B from a byte stream and serves a row of A plus a
// column of B per request, one response every two cycles.
module matrix_fetch
  import mat_pkg::*;
#(
    parameter int N      = 32,
    parameter int DATA_W = 8
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    matrix_fetch_if.slave  bus
);
    localparam int IW = $clog2(N);
    localparam int CW = 2 * IW + 1;

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_READY = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          complete_q, complete_d;
    logic          val_q, val_d;
    logic          ovf_q, ovf_d;
    logic [IW-1:0] row_in_q, col_in_q;

    logic          byte_acc;
    logic          serve;
    logic          we_a, we_b;

    // A restart pulse outranks any byte or request arriving with it.
    assign byte_acc = (state_q == S_LOAD) && bus.byte_valid_in && !bus.load_start_in;
    assign serve    = (state_q == S_READY) && bus.new_request && !bus.load_start_in;
    assign we_a     = byte_acc && !cnt_q[CW-1];
    assign we_b     = byte_acc &&  cnt_q[CW-1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        complete_d = complete_q;
        ovf_d      = ovf_q;
        val_d      = 1'b0;
        if (bus.load_start_in) begin
            state_d    = S_LOAD;
            cnt_d      = '0;
            complete_d = 1'b0;
            ovf_d      = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (bus.byte_valid_in) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == '1) begin
                            state_d    = S_READY;
                            complete_d = 1'b1;
                        end
                    end
                end
                S_READY: begin
                    if (bus.byte_valid_in) ovf_d = 1'b1;
                    if (bus.new_request) begin
                        val_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
                S_RESP: begin
                    // Requests are not sampled here: the consumer is still
                    // switching its indices after seeing val_rows.
                    if (bus.byte_valid_in) ovf_d = 1'b1;
                    state_d = S_READY;
                end
                default: state_d = S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            complete_q <= 1'b0;
            val_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            complete_q <= complete_d;
            val_q      <= val_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            row_in_q <= '0;
            col_in_q <= '0;
        end else if (serve) begin
            row_in_q <= bus.row_req;
            col_in_q <= bus.col_req;
        end
    end

    // A is stored row-major; B is stored transposed so one word is a column.
    mat_store #(.N(N), .DATA_W(DATA_W)) u_store_a (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .we_i     (we_a),
        .waddr_i  (cnt_q[2*IW-1:IW]),
        .wlane_i  (cnt_q[IW-1:0]),
        .wdata_i  (bus.byte_in),
        .re_i     (serve),
        .raddr_i  (bus.row_req),
        .rdata_o  (bus.matA_row)
    );

    mat_store #(.N(N), .DATA_W(DATA_W)) u_store_b (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .we_i     (we_b),
        .waddr_i  (cnt_q[IW-1:0]),
        .wlane_i  (cnt_q[2*IW-1:IW]),
        .wdata_i  (bus.byte_in),
        .re_i     (serve),
        .raddr_i  (bus.col_req),
        .rdata_o  (bus.matB_col)
    );

    assign bus.complete     = complete_q;
    assign bus.val_rows     = val_q;
    assign bus.overflow_out = ovf_q;
    assign bus.row_in       = row_in_q;
    assign bus.col_in       = col_in_q;
    assign bus.dbg_state    = fetch_state_t'(state_q);
endmodule

// File: tb/tb_matrix_fetch.sv
// Self-checking bench for matrix_fetch: random and patterned loads checked
// against array models of A and B indexed by stream position.
module tb_matrix_fetch;
  logic clk_in;
  logic rst_n_in;

  matrix_fetch_if bus();

  matrix_fetch dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  // clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // reference model and counters
  logic [7:0] ref_a [32][32];
  logic [7:0] ref_b [32][32];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat1(input int i);
    int r, c;
    if (i < 1024) begin
      r = i / 32; c = i % 32;
      return 8'((r * 32 + c) & 255);
    end
    r = (i - 1024) / 32; c = (i - 1024) % 32;
    return 8'((r + 2 * c) & 255);
  endfunction

  task automatic model_write(input int i, input logic [7:0] b);
    if (i < 1024) ref_a[i / 32][i % 32] = b;
    else          ref_b[(i - 1024) / 32][(i - 1024) % 32] = b;
  endtask

  function automatic logic [255:0] exp_row(input int r);
    logic [255:0] v;
    for (int k = 0; k < 32; k++) v[k*8 +: 8] = ref_a[r][k];
    return v;
  endfunction

  function automatic logic [255:0] exp_col(input int c);
    logic [255:0] v;
    for (int k = 0; k < 32; k++) v[k*8 +: 8] = ref_b[k][c];
    return v;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic load_range(input int first, input int last, input bit rnd,
                            input bit gapped, input bit chk_quiet);
    logic [7:0] b;
    for (int i = first; i <= last; i++) begin
      if (gapped) repeat ($urandom_range(0, 2)) step();
      b = rnd ? 8'($urandom) : pat1(i);
      model_write(i, b);
      if (i == 2047) check_eq("complete_before_last", 256'(bus.complete), 256'(0));
      bus.byte_in = b;
      bus.byte_valid_in = 1'b1;
      step();
      bus.byte_valid_in = 1'b0;
      if (chk_quiet) check_eq("val_rows_while_loading", 256'(bus.val_rows), 256'(0));
      if (i == 2047) check_eq("complete_after_last", 256'(bus.complete), 256'(1));
    end
  endtask

  task automatic check_resp(input string tag, input int r, input int c);
    check_eq({tag, "_val"}, 256'(bus.val_rows), 256'(1));
    check_eq({tag, "_row_in"}, 256'(bus.row_in), 256'(r));
    check_eq({tag, "_col_in"}, 256'(bus.col_in), 256'(c));
    check_eq({tag, "_rowA"}, bus.matA_row, exp_row(r));
    check_eq({tag, "_colB"}, bus.matB_col, exp_col(c));
  endtask

  task automatic request(input string tag, input int r, input int c);
    bus.new_request = 1'b1;
    bus.row_req = 5'(r);
    bus.col_req = 5'(c);
    step();
    bus.new_request = 1'b0;
    check_resp(tag, r, c);
    step();
    check_eq({tag, "_val_drop"}, 256'(bus.val_rows), 256'(0));
  endtask

  task automatic pulse_restart(input bit with_byte);
    bus.load_start_in = 1'b1;
    bus.byte_valid_in = with_byte;
    bus.byte_in = 8'hA5;
    step();
    bus.load_start_in = 1'b0;
    bus.byte_valid_in = 1'b0;
  endtask

  // scoreboard for the held-request sweep
  logic [9:0] exp_q[$];

  initial begin
    logic [255:0] fixed;
    int waited;
    int nr;
    int nc;
    logic [9:0] e;

    bus.byte_in = '0;
    bus.byte_valid_in = 1'b0;
    bus.load_start_in = 1'b0;
    bus.new_request = 1'b0;
    bus.row_req = '0;
    bus.col_req = '0;
    rst_n_in = 1'b0;
    repeat (3) step();
    check_eq("reset_complete", 256'(bus.complete), 256'(0));
    check_eq("reset_val_rows", 256'(bus.val_rows), 256'(0));
    check_eq("reset_overflow", 256'(bus.overflow_out), 256'(0));
    check_eq("reset_rowA", bus.matA_row, 256'(0));
    check_eq("reset_colB", bus.matB_col, 256'(0));
    check_eq("reset_row_in", 256'(bus.row_in), 256'(0));
    #2 rst_n_in = 1'b1;
    step();

    // 1: back-to-back load, first request
    load_range(0, 2047, 1'b0, 1'b0, 1'b0);
    request("s1_req35", 3, 5);
    for (int k = 0; k < 32; k++) fixed[k*8 +: 8] = 8'((96 + k) & 255);
    check_eq("s1_rowA_literal", bus.matA_row, fixed);
    for (int k = 0; k < 32; k++) fixed[k*8 +: 8] = 8'((k + 10) & 255);
    check_eq("s1_colB_literal", bus.matB_col, fixed);

    // 2: held request, consumer updates indices on val_rows
    for (int i = 0; i < 33; i++) exp_q.push_back(10'(i));
    bus.row_req = '0;
    bus.col_req = '0;
    bus.new_request = 1'b1;
    for (int i = 0; i < 33; i++) begin
      waited = 0;
      do begin
        step();
        waited++;
      end while (!bus.val_rows && waited < 6);
      if (!bus.val_rows) begin
        check_eq("s2_timeout", 256'(0), 256'(1));
        break;
      end
      e = exp_q.pop_front();
      check_eq("s2_gap", 256'(waited), 256'((i == 0) ? 1 : 2));
      check_resp("s2_held", int'(e[9:5]), int'(e[4:0]));
      nr = (i + 1) / 32;
      nc = (i + 1) % 32;
      bus.row_req = 5'(nr);
      bus.col_req = 5'(nc);
    end
    bus.new_request = 1'b0;
    step();
    step();

    // 4a: a stray byte after a full load sets overflow, contents untouched
    bus.byte_in = 8'h5A;
    bus.byte_valid_in = 1'b1;
    step();
    bus.byte_valid_in = 1'b0;
    check_eq("s4_overflow_set", 256'(bus.overflow_out), 256'(1));
    request("s4_after_overflow", 3, 5);
    check_eq("s4_overflow_sticky", 256'(bus.overflow_out), 256'(1));

    // 4b: restart with a coincident byte that must be dropped
    pulse_restart(1'b1);
    check_eq("s4_restart_complete", 256'(bus.complete), 256'(0));
    check_eq("s4_restart_overflow", 256'(bus.overflow_out), 256'(0));

    // 3: request held from byte 1000 onward is served once complete rises
    load_range(0, 999, 1'b1, 1'b0, 1'b0);
    bus.row_req = 5'd7;
    bus.col_req = 5'd7;
    bus.new_request = 1'b1;
    load_range(1000, 2047, 1'b1, 1'b0, 1'b1);
    step();
    bus.new_request = 1'b0;
    check_resp("s3_early_req", 7, 7);
    step();
    request("s4_reload_req", 31, 31);

    // 5: asynchronous reset partway through a load
    pulse_restart(1'b0);
    load_range(0, 499, 1'b1, 1'b0, 1'b0);
    #2 rst_n_in = 1'b0;
    #1;
    check_eq("s5_rst_complete", 256'(bus.complete), 256'(0));
    check_eq("s5_rst_val_rows", 256'(bus.val_rows), 256'(0));
    check_eq("s5_rst_rowA", bus.matA_row, 256'(0));
    check_eq("s5_rst_colB", bus.matB_col, 256'(0));
    check_eq("s5_rst_row_in", 256'(bus.row_in), 256'(0));
    check_eq("s5_rst_col_in", 256'(bus.col_in), 256'(0));
    #3 rst_n_in = 1'b1;
    load_range(0, 2047, 1'b1, 1'b0, 1'b0);
    request("s5_req_0_31", 0, 31);

    // 6: gapped stream of the scenario-1 pattern, plus random requests
    pulse_restart(1'b0);
    load_range(0, 2047, 1'b0, 1'b1, 1'b0);
    request("s6_req35", 3, 5);
    for (int i = 0; i < 6; i++) begin
      request("s6_rand", $urandom_range(0, 31), $urandom_range(0, 31));
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_fetch.md
# matrix_fetch

Upstream operand server for the matrix-multiply datapath. It captures two 32×32 byte matrices, A then B, from a byte stream such as the UART receiver, and raises `complete` once both are stored. It then answers row/column requests from the algorithm stage with a full row of A and a full column of B, each tagged with the indices that were requested.

## Interface
Parameters:
- `N`, 32: matrix dimension; indices are `$clog2(N)` = 5 bits.
- `DATA_W`, 8: element width in bits.

Ports:
- `clk_in` input 1: single clock; all logic is on its rising edge.
- `rst_n_in` input 1: reset, asynchronous and active-low.
- `byte_in` input 8: load data byte.
- `byte_valid_in` input 1: `byte_in` is valid this cycle.
- `load_start_in` input 1: one-cycle pulse that restarts a load.
- `new_request` input 1: consumer wants the data for `row_req`/`col_req`.
- `row_req` input 5: requested row of A.
- `col_req` input 5: requested column of B.
- `complete` output 1: both matrices are loaded (level).
- `matA_row` output [31:0][7:0]: `A[row_in][k]` on element k.
- `matB_col` output [31:0][7:0]: `B[k][col_in]` on element k.
- `row_in` output 5: echo of the served row.
- `col_in` output 5: echo of the served column.
- `val_rows` output 1: one-cycle strobe marking the response outputs valid.
- `overflow_out` output 1: sticky; a byte arrived after 2048 bytes were loaded.

## Operation
States are `S_LOAD`, `S_READY` and `S_RESP`.

- **Reset**:
  - Applies the values below asynchronously.
  - Clears the 11-bit byte counter.
  - Leaves matrix contents undefined.
  - `complete`, `val_rows` and `overflow_out` go to 0; `matA_row`, `matB_col`, `row_in` and `col_in` go to 0; the state goes to `S_LOAD`.
- **S_LOAD**:
  - Each cycle with `byte_valid_in` high writes one byte, then increments the counter `cnt`.
  - `cnt[10]=0` selects A; the element is `A[cnt[9:5]][cnt[4:0]]` (row-major).
  - `cnt[10]=1` selects B; the element is `B[cnt[9:5]][cnt[4:0]]`. B is stored transposed, so it writes column word `cnt[4:0]`, byte lane `cnt[9:5]`.
  - The byte that makes `cnt` reach 2048 moves the state to `S_READY` and sets `complete` on the same edge.
  - `new_request` is ignored here, so `val_rows` stays 0.
- **S_READY**:
  - If `new_request` is high, register `A[row_req]`, `B[col_req]`, `row_req` and `col_req` onto the outputs.
  - Assert `val_rows` and move to `S_RESP`.
- **S_RESP**:
  - Deassert `val_rows` and return to `S_READY` unconditionally.
  - `new_request` is not sampled in this state. The consumer holds `new_request` high and updates `row_req`/`col_req` on the edge where it sees `val_rows`, so sampling here would re-serve the stale indices.
- **Response hold**: the data outputs keep their value until the next response.
- **load_start_in**:
  - Takes effect in any state and has priority over a request or byte arriving in the same cycle.
  - Clears `cnt`, `complete`, `val_rows` and `overflow_out`, and moves the state to `S_LOAD`.
  - A byte that is valid in the same cycle is dropped.
- **Bytes in S_READY/S_RESP**: ignored, and set `overflow_out`. Matrix contents are not modified.

## Timing
- **Load**: one byte per cycle at full rate. `complete` is high in the cycle after the 2048th valid byte.
- **Request latency**: the request is sampled at edge t, and the outputs plus `val_rows=1` are valid in the cycle after edge t. The earliest next sample is at edge t+2.
- **Throughput**: one response per 2 cycles.
- **Response fields**: `row_in`, `col_in` and the data always belong to the same request.
- **Level signals**: `complete` is a level; the consumer edge-detects it. It falls only on reset or `load_start_in`.
- **Index range**: no range checks are needed, because 5-bit indices fully cover N=32.

## Structure
- **Package `mat_pkg`**: holds `N`, `DATA_W`, `IDX_W=5` and `BYTES_PER_MAT=1024`. It also holds the `row_t` typedef (`logic [N-1:0][DATA_W-1:0]`) and the enum `fetch_state_t`.
- **Sub-module `mat_store`**:
  - Behaviour: an N-word × `row_t` array with a byte write (word address, lane, data, enable) and a registered whole-word read.
  - Instantiated twice. The A instance writes at (row, col); the B instance writes at (col, row), which makes the word read for B the column of B.
- **Top level**: holds the counter, the FSM, the overflow flag and the output registers.

## Test plan
1. **Load A and B**: stream `A[r][c]=(r*32+c)&8'hFF`, then `B[r][c]=(r+2*c)&8'hFF` (2048 bytes, back-to-back), then request (3,5).
   - `complete` rises exactly one cycle after the last byte.
   - `matA_row[k]=(96+k)&8'hFF`, `matB_col[k]=(k+10)&8'hFF`, `row_in=3`, `col_in=5`, and `val_rows` is high for exactly 1 cycle.
2. **Held new_request**: hold `new_request` high and emulate the consumer's index update on `val_rows`.
   - Responses arrive every 2 cycles with the sequence (0,0), (0,1), …, (0,31), (1,0), and no index repeats.
3. **Request before complete**: drive `new_request` with (7,7) while only 1000 bytes are loaded.
   - `val_rows` stays 0. The request is served 1 cycle after `complete` rises, if it is still held.
4. **Overflow and restart**: send a 2049th byte.
   - `overflow_out` goes to 1 and the contents are unchanged.
   - Then pulse `load_start_in` together with `byte_valid_in`: `complete` and `overflow_out` go to 0, and that byte is not counted. A full reload followed by request (31,31) returns the new data.
5. **Async reset mid-load**: drop `rst_n_in` away from any clock edge after 500 bytes.
   - All outputs go to 0 immediately.
   - After release, 2048 new bytes set `complete`, and request (0,31) returns the new `A[0]` row and the new `B[·][31]` column.
6. **Gapped input**: feed `byte_valid_in` with random gaps.
   - Served data is identical to scenario 1, and `complete` rises exactly one cycle after the 2048th valid byte.
